// File: rtl/psec_spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : psec_spi_pkg
//  Description : Shared types and default constants for the SPI register
//                access scheduler and its byte FIFO.
//                  byte_t  - one SPI / register-bank byte
//                  state_e - frame interpreter states
//  Revision    : 1.0 - initial release
// ============================================================================
package psec_spi_pkg;

   typedef logic [7:0] byte_t;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,   // waiting for the address byte of a frame
      ST_RD_ADDR  = 3'd1,   // readback read of the current pointer
      ST_ADDR_SET = 3'd2,   // pointer valid, waiting for a data byte
      ST_WR       = 3'd3,   // bank write of the latched data byte
      ST_INC      = 3'd4    // pointer auto-increment
   } state_e;

   localparam int unsigned DEF_FIFO_DEPTH = 4;
   localparam int unsigned DEF_STARVE_MAX = 4;
   localparam int unsigned DEF_NUM_REGS   = 32;

endpackage
`default_nettype wire

// File: rtl/spi_byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : spi_byte_fifo
//  Description : Small synchronous FIFO buffering SPI bytes in the iclk
//                domain. A push while full is dropped and flags overflow
//                (sticky until rstn); a push together with a pop while full
//                is accepted.
//  Ports       : iclk, rstn        - clock, async active-low reset
//                push, push_data   - write request and data
//                pop               - read request (ignored when empty)
//                pop_data          - head entry (combinational)
//                empty             - no entries stored
//                ovf               - sticky overflow flag
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_byte_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 9
) (
   input  logic             iclk,
   input  logic             rstn,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             empty,
   output logic             ovf
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_full;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign empty     = (r_count == '0);
   assign w_full    = (r_count == (AW+1)'(DEPTH));
   assign w_pop_ok  = pop && !empty;
   // A full FIFO still accepts a byte when the head leaves in the same cycle.
   assign w_push_ok = push && (!w_full || w_pop_ok);
   assign pop_data  = r_mem[r_rd_ptr];

   always_ff @(posedge iclk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge iclk or negedge rstn) begin
      if (!rstn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         ovf      <= 1'b0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         if (w_push_ok && !w_pop_ok) begin
            r_count <= r_count + (AW+1)'(1);
         end else if (!w_push_ok && w_pop_ok) begin
            r_count <= r_count - (AW+1)'(1);
         end
         if (push && !w_push_ok) begin
            ovf <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/spi_reg_access_sched.sv
`default_nettype none
// ============================================================================
//  Module      : spi_reg_access_sched
//  Description : Frame interpreter between the SPI byte front-end and the
//                register bank. First byte of a frame is the address
//                pointer, every following byte is written at the pointer,
//                which then auto-increments. Each pointer value is read back
//                for the POCI shifter. The single bank port is shared with
//                an internal requester: SPI wins, but after STARVE_MAX
//                consecutive denials the internal request takes one cycle.
//  Ports       : iclk, rstn                      - clock, async reset
//                byte_valid/byte_data/frame_end  - SPI byte front-end
//                int_req/int_we/int_addr/int_wdata, int_gnt/int_rdata
//                                                - internal requester
//                rf_we/rf_re/rf_addr/rf_wdata/rf_rdata - bank port
//                poci_data/poci_load             - readback byte
//                fifo_ovf, busy                  - status
//                addr_err                        - only with the macro below
//  Options     : PSEC_ADDR_RANGE_CHECK_EN - suppress SPI accesses with
//                pointer >= NUM_REGS and pulse addr_err for each one.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_access_sched
   import psec_spi_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
`ifdef PSEC_ADDR_RANGE_CHECK_EN
   ,
   parameter int unsigned NUM_REGS   = DEF_NUM_REGS
`endif
) (
   input  logic  iclk,
   input  logic  rstn,
   input  logic  byte_valid,
   input  byte_t byte_data,
   input  logic  frame_end,
   input  logic  int_req,
   input  logic  int_we,
   input  byte_t int_addr,
   input  byte_t int_wdata,
   output logic  int_gnt,
   output byte_t int_rdata,
   output logic  rf_we,
   output logic  rf_re,
   output byte_t rf_addr,
   output byte_t rf_wdata,
   input  byte_t rf_rdata,
   output byte_t poci_data,
   output logic  poci_load,
   output logic  fifo_ovf,
`ifdef PSEC_ADDR_RANGE_CHECK_EN
   output logic  addr_err,
`endif
   output logic  busy
);

   localparam int unsigned SW = $clog2(STARVE_MAX + 1);

   state_e        r_state;
   byte_t         r_ptr;
   byte_t         r_data;
   logic [SW-1:0] r_starve;
   logic          r_new_frame;   // next pushed byte opens a new frame
   logic          r_spi_rd;      // current bank cycle is an SPI readback
`ifdef PSEC_ADDR_RANGE_CHECK_EN
   logic          r_rd_null;     // suppressed readback, return 0x00
   logic          w_out_range;
`endif

   logic [8:0]    w_head;
   logic          w_head_first;
   byte_t         w_head_byte;
   logic          w_empty;
   logic          w_pop;
   logic          w_spi_op;
   logic          w_int_win;

   // Each FIFO entry carries a frame-start tag so a byte of the next frame
   // queued behind the closing frame is never taken as data.
   spi_byte_fifo #(
      .DEPTH     (FIFO_DEPTH),
      .WIDTH     (9)
   ) u_fifo (
      .iclk      (iclk),
      .rstn      (rstn),
      .push      (byte_valid),
      .push_data ({r_new_frame, byte_data}),
      .pop       (w_pop),
      .pop_data  (w_head),
      .empty     (w_empty),
      .ovf       (fifo_ovf)
   );

   assign w_head_first = w_head[8];
   assign w_head_byte  = w_head[7:0];

   assign w_spi_op  = (r_state == ST_RD_ADDR) || (r_state == ST_WR);
   assign w_int_win = int_req && (!w_spi_op || (r_starve == SW'(STARVE_MAX)));

`ifdef PSEC_ADDR_RANGE_CHECK_EN
   assign w_out_range = (32'(r_ptr) >= NUM_REGS);
`endif

   assign int_rdata = (int_gnt && rf_re) ? rf_rdata : '0;
   assign busy      = (r_state != ST_IDLE) || !w_empty;

   always_comb begin
      w_pop = 1'b0;
      case (r_state)
         ST_IDLE:     w_pop = !w_empty;
         ST_ADDR_SET: w_pop = !w_empty && !w_head_first;
         default:     w_pop = 1'b0;
      endcase
   end

   always_ff @(posedge iclk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= ST_IDLE;
         r_ptr       <= '0;
         r_data      <= '0;
         r_starve    <= '0;
         r_new_frame <= 1'b1;
         r_spi_rd    <= 1'b0;
         int_gnt     <= 1'b0;
         rf_we       <= 1'b0;
         rf_re       <= 1'b0;
         rf_addr     <= '0;
         rf_wdata    <= '0;
         poci_data   <= '0;
         poci_load   <= 1'b0;
`ifdef PSEC_ADDR_RANGE_CHECK_EN
         r_rd_null   <= 1'b0;
         addr_err    <= 1'b0;
`endif
      end else begin
         rf_we     <= 1'b0;
         rf_re     <= 1'b0;
         int_gnt   <= 1'b0;
         poci_load <= 1'b0;
         r_spi_rd  <= 1'b0;
`ifdef PSEC_ADDR_RANGE_CHECK_EN
         r_rd_null <= 1'b0;
         addr_err  <= 1'b0;
`endif

         // A byte arriving together with frame_end still belongs to the
         // closing frame, so frame_end takes priority over the clear.
         if (frame_end) begin
            r_new_frame <= 1'b1;
         end else if (byte_valid) begin
            r_new_frame <= 1'b0;
         end

         // Readback data is sampled at the end of the SPI read cycle.
         if (r_spi_rd) begin
            poci_data <= rf_rdata;
            poci_load <= 1'b1;
         end
`ifdef PSEC_ADDR_RANGE_CHECK_EN
         else if (r_rd_null) begin
            poci_data <= '0;
            poci_load <= 1'b1;
         end
`endif

         if (w_int_win) begin
            r_starve <= '0;
            int_gnt  <= 1'b1;
            rf_we    <= int_we;
            rf_re    <= !int_we;
            rf_addr  <= int_addr;
            if (int_we) begin
               rf_wdata <= int_wdata;
            end
         end else if (int_req) begin
            r_starve <= r_starve + SW'(1);
         end

         case (r_state)
            ST_IDLE: begin
               if (!w_empty) begin
                  r_ptr   <= w_head_byte;
                  r_state <= ST_RD_ADDR;
               end
            end
            ST_RD_ADDR: begin
               if (!w_int_win) begin
`ifdef PSEC_ADDR_RANGE_CHECK_EN
                  if (w_out_range) begin
                     r_rd_null <= 1'b1;
                     addr_err  <= 1'b1;
                  end else begin
                     rf_re    <= 1'b1;
                     rf_addr  <= r_ptr;
                     r_spi_rd <= 1'b1;
                  end
`else
                  rf_re    <= 1'b1;
                  rf_addr  <= r_ptr;
                  r_spi_rd <= 1'b1;
`endif
                  r_state <= ST_ADDR_SET;
               end
            end
            ST_ADDR_SET: begin
               if (!w_empty) begin
                  if (w_head_first) begin
                     r_state <= ST_IDLE;
                  end else begin
                     r_data  <= w_head_byte;
                     r_state <= ST_WR;
                  end
               end else if (r_new_frame) begin
                  r_state <= ST_IDLE;
               end
            end
            ST_WR: begin
               if (!w_int_win) begin
`ifdef PSEC_ADDR_RANGE_CHECK_EN
                  if (w_out_range) begin
                     addr_err <= 1'b1;
                  end else begin
                     rf_we    <= 1'b1;
                     rf_addr  <= r_ptr;
                     rf_wdata <= r_data;
                  end
`else
                  rf_we    <= 1'b1;
                  rf_addr  <= r_ptr;
                  rf_wdata <= r_data;
`endif
                  r_state <= ST_INC;
               end
            end
            ST_INC: begin
               r_ptr   <= r_ptr + 8'd1;
               r_state <= ST_RD_ADDR;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_access_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_reg_access_sched
//  Description : Directed scoreboard bench for spi_reg_access_sched. The
//                register bank is modelled as rf_rdata = rf_addr ^ 0x5A.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_reg_access_sched;

   logic       iclk       = 1'b0;
   logic       rstn       = 1'b1;
   logic       byte_valid = 1'b0;
   logic [7:0] byte_data  = 8'h00;
   logic       frame_end  = 1'b0;
   logic       int_req    = 1'b0;
   logic       int_we     = 1'b0;
   logic [7:0] int_addr   = 8'h00;
   logic [7:0] int_wdata  = 8'h00;
   logic       int_gnt;
   logic [7:0] int_rdata;
   logic       rf_we;
   logic       rf_re;
   logic [7:0] rf_addr;
   logic [7:0] rf_wdata;
   logic [7:0] rf_rdata;
   logic [7:0] poci_data;
   logic       poci_load;
   logic       fifo_ovf;
   logic       busy;

   int checks = 0;
   int errors = 0;

   logic [15:0] wq[$];   // {addr, data} of expected SPI writes
   logic [7:0]  rq[$];   // addresses of expected SPI reads
   logic [7:0]  pq[$];   // expected poci_data values
   logic [17:0] iq[$];   // {we, re, addr, wdata or rdata} of internal ops

   always #5 iclk = ~iclk;

   function automatic logic [7:0] f_bank(input logic [7:0] a);
      return a ^ 8'h5A;
   endfunction

   assign rf_rdata = f_bank(rf_addr);

   spi_reg_access_sched #(
      .FIFO_DEPTH (4),
      .STARVE_MAX (4)
   ) dut (
      .iclk       (iclk),
      .rstn       (rstn),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .frame_end  (frame_end),
      .int_req    (int_req),
      .int_we     (int_we),
      .int_addr   (int_addr),
      .int_wdata  (int_wdata),
      .int_gnt    (int_gnt),
      .int_rdata  (int_rdata),
      .rf_we      (rf_we),
      .rf_re      (rf_re),
      .rf_addr    (rf_addr),
      .rf_wdata   (rf_wdata),
      .rf_rdata   (rf_rdata),
      .poci_data  (poci_data),
      .poci_load  (poci_load),
      .fifo_ovf   (fifo_ovf),
      .busy       (busy)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name);
      checks++;
      errors++;
      $display("FAIL %s unexpected output t=%0t addr=%0h", name, $time, rf_addr);
   endtask

   function automatic logic [63:0] out_vec();
      return {26'd0, int_gnt, int_rdata, rf_we, rf_re, rf_addr, rf_wdata,
              poci_data, poci_load, fifo_ovf, busy};
   endfunction

   // ---------------- monitor ----------------
   always @(negedge iclk) begin
      if (rstn) begin
         if (rf_we || rf_re) begin
            chk("we_re_exclusive", {63'd0, rf_we & rf_re}, 64'd0);
         end
         if (int_gnt) begin
            if (iq.size() == 0) begin
               unexpected("int_gnt");
            end else begin
               chk("int_op", {46'd0, rf_we, rf_re, rf_addr, (rf_we ? rf_wdata : int_rdata)},
                   {46'd0, iq.pop_front()});
            end
         end else begin
            if (rf_we) begin
               if (wq.size() == 0) unexpected("spi_write");
               else chk("spi_write", {48'd0, rf_addr, rf_wdata}, {48'd0, wq.pop_front()});
            end
            if (rf_re) begin
               if (rq.size() == 0) unexpected("spi_read");
               else chk("spi_read_addr", {56'd0, rf_addr}, {56'd0, rq.pop_front()});
            end
         end
         if (poci_load) begin
            if (pq.size() == 0) unexpected("poci_load");
            else chk("poci_data", {56'd0, poci_data}, {56'd0, pq.pop_front()});
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic align();
      @(posedge iclk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) align();
   endtask

   task automatic send_byte(input logic [7:0] b, input logic fe);
      byte_valid = 1'b1;
      byte_data  = b;
      frame_end  = fe;
      align();
      byte_valid = 1'b0;
      frame_end  = 1'b0;
   endtask

   task automatic send_fe();
      frame_end = 1'b1;
      align();
      frame_end = 1'b0;
   endtask

   task automatic exp_rd(input logic [7:0] a);
      rq.push_back(a);
      pq.push_back(f_bank(a));
   endtask

   task automatic exp_wr(input logic [7:0] a, input logic [7:0] d);
      wq.push_back({a, d});
   endtask

   task automatic wait_idle(input string name, input int bound);
      int n;
      n = 0;
      while (busy && n < bound) begin
         @(negedge iclk);
         n++;
      end
      chk(name, {63'd0, busy}, 64'd0);
      align();
   endtask

   task automatic int_access(input logic we, input logic [7:0] addr, input logic [7:0] wd);
      int n;
      iq.push_back({we, ~we, addr, (we ? wd : f_bank(addr))});
      int_we    = we;
      int_addr  = addr;
      int_wdata = wd;
      int_req   = 1'b1;
      n = 0;
      do begin
         @(negedge iclk);
         n++;
      end while (!int_gnt && n < 10);
      checks++;
      if (!int_gnt || n > 5) begin
         errors++;
         $display("FAIL int_gnt_latency actual=%0d cycles required<=5", n);
      end
      int_req = 1'b0;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      #2 rstn = 1'b0;
      repeat (2) @(posedge iclk);
      #1;
      chk("reset_outputs", out_vec(), 64'd0);
      rstn = 1'b1;
      align();

      // Basic frame: address 0x05, two data bytes.
      exp_rd(8'h05); exp_wr(8'h05, 8'hA1);
      exp_rd(8'h06); exp_wr(8'h06, 8'hB2);
      exp_rd(8'h07);
      send_byte(8'h05, 1'b0); idle(3);
      send_byte(8'hA1, 1'b0); idle(3);
      send_byte(8'hB2, 1'b0); idle(3);
      send_fe();
      wait_idle("frame1_idle", 40);
      chk("ovf_clear", {63'd0, fifo_ovf}, 64'd0);

      // Pointer wrap 0xFF -> 0x00.
      exp_rd(8'hFF); exp_wr(8'hFF, 8'h11);
      exp_rd(8'h00); exp_wr(8'h00, 8'h22);
      exp_rd(8'h01);
      send_byte(8'hFF, 1'b0); idle(3);
      send_byte(8'h11, 1'b0); idle(3);
      send_byte(8'h22, 1'b0); idle(3);
      send_fe();
      wait_idle("wrap_idle", 40);

      // Overflow: eight back-to-back bytes; 0x06 arrives while full with
      // no pop and is dropped, 0x07 arrives with a pop and is accepted.
      exp_wr(8'h40, 8'h01); exp_wr(8'h41, 8'h02); exp_wr(8'h42, 8'h03);
      exp_wr(8'h43, 8'h04); exp_wr(8'h44, 8'h05); exp_wr(8'h45, 8'h07);
      for (int i = 0; i < 7; i++) exp_rd(8'h40 + 8'(i));
      send_byte(8'h40, 1'b0);
      send_byte(8'h01, 1'b0);
      send_byte(8'h02, 1'b0);
      send_byte(8'h03, 1'b0);
      send_byte(8'h04, 1'b0);
      send_byte(8'h05, 1'b0);
      send_byte(8'h06, 1'b0);
      send_byte(8'h07, 1'b0);
      send_fe();
      wait_idle("ovf_idle", 80);
      chk("ovf_set", {63'd0, fifo_ovf}, 64'd1);

      // frame_end coincident with the last data byte, next byte is an address.
      exp_rd(8'h10); exp_wr(8'h10, 8'h33); exp_rd(8'h11);
      exp_rd(8'h20);
      send_byte(8'h10, 1'b0); idle(3);
      send_byte(8'h33, 1'b1);
      send_byte(8'h20, 1'b0); idle(8);
      send_fe();
      wait_idle("fe_coinc_idle", 40);
      chk("ovf_sticky", {63'd0, fifo_ovf}, 64'd1);

      // Contention: internal write and read during an SPI burst.
      exp_rd(8'h80); exp_wr(8'h80, 8'h01);
      exp_rd(8'h81); exp_wr(8'h81, 8'h02);
      exp_rd(8'h82); exp_wr(8'h82, 8'h03);
      exp_rd(8'h83); exp_wr(8'h83, 8'h04);
      exp_rd(8'h84);
      fork
         begin
            send_byte(8'h80, 1'b0); idle(1);
            send_byte(8'h01, 1'b0); idle(1);
            send_byte(8'h02, 1'b0); idle(1);
            send_byte(8'h03, 1'b0); idle(1);
            send_byte(8'h04, 1'b0);
         end
         begin
            idle(3);
            int_access(1'b1, 8'hC0, 8'h99);
            align();
            int_access(1'b0, 8'hC1, 8'h00);
         end
      join
      idle(12);
      send_fe();
      wait_idle("contend_idle", 60);

      // Reset between the address byte and the data byte.
      exp_rd(8'h30);
      send_byte(8'h30, 1'b0); idle(6);
      #2 rstn = 1'b0;
      #1 chk("midframe_reset_outputs", out_vec(), 64'd0);
      repeat (2) @(posedge iclk);
      #3 rstn = 1'b1;
      align();
      exp_rd(8'h31); exp_wr(8'h31, 8'h77); exp_rd(8'h32);
      send_byte(8'h31, 1'b0); idle(3);
      send_byte(8'h77, 1'b0); idle(3);
      send_fe();
      wait_idle("post_reset_idle", 40);
      chk("ovf_cleared_by_reset", {63'd0, fifo_ovf}, 64'd0);

      idle(4);
      chk("wq_drained", 64'(wq.size()), 64'd0);
      chk("rq_drained", 64'(rq.size()), 64'd0);
      chk("pq_drained", 64'(pq.size()), 64'd0);
      chk("iq_drained", 64'(iq.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
